// File: rtl/alu_exec_pkg.sv
// Shared op-codes, widths and FSM encoding for the execute-stage ALU.
// ALU_EXEC_RADIX4_MUL_EN selects a 2-bit-per-cycle multiplier.
package alu_exec_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SLT   = 4'd7;
  localparam logic [3:0] OP_MUL   = 4'd8;
  localparam logic [3:0] OP_NOR   = 4'd12;
  localparam logic [3:0] OP_SLTU  = 4'd13;
  localparam logic [3:0] OP_SHIFT = 4'd14;

`ifdef ALU_EXEC_RADIX4_MUL_EN
  localparam int MUL_STEP = 2;
`else
  localparam int MUL_STEP = 1;
`endif
  localparam int MUL_ITERS = DATA_W / MUL_STEP;
  localparam int CNT_W     = $clog2(MUL_ITERS);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low DATA_W bits of a*b.
// ALU_EXEC_RADIX4_MUL_EN retires two multiplier bits per iteration.
module alu_mul_iter
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_ITERS - 1);

  logic              running;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mcand, mplier, acc, partial, acc_next;

  always_comb begin
    partial = '0;
`ifdef ALU_EXEC_RADIX4_MUL_EN
    case (mplier[1:0])
      2'd1:    partial = mcand;
      2'd2:    partial = mcand << 1;
      2'd3:    partial = mcand + (mcand << 1);
      default: partial = '0;
    endcase
`else
    if (mplier[0]) partial = mcand;
`endif
    acc_next = acc + partial;
  end

  // done fires during the last iteration so the caller can register acc_next
  // at the same edge that retires it.
  assign done    = running && (cnt == LAST);
  assign product = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc     <= acc_next;
      mcand   <= mcand << MUL_STEP;
      mplier  <= mplier >> MUL_STEP;
      cnt     <= cnt + 1'b1;
      if (cnt == LAST) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ops plus an iterative MUL that stalls via busy_o.
// ALU_EXEC_RADIX4_MUL_EN halves MUL latency (16 iterations instead of 32).
module alu_exec
  import alu_exec_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [3:0]        ALUCtrl_i,
  input  logic              shamt_sel_i,
  input  logic [4:0]        shamt_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              valid_o,
  output logic              busy_o
);

  state_t            state, next_state;
  logic              accept, mul_start, mul_done;
  logic [4:0]        amt;
  logic [DATA_W-1:0] alu_res, mul_prod;

  assign accept    = valid_i && !busy_o;
  assign mul_start = accept && (ALUCtrl_i == OP_MUL);

  always_comb begin
    amt     = shamt_sel_i ? shamt_i : src1_i[4:0];
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:   alu_res = src1_i & src2_i;
      OP_OR:    alu_res = src1_i | src2_i;
      OP_ADD:   alu_res = src1_i + src2_i;
      OP_SUB:   alu_res = src1_i - src2_i;
      OP_SLT:   alu_res = {31'd0, $signed(src1_i) < $signed(src2_i)};
      OP_SLTU:  alu_res = {31'd0, src1_i < src2_i};
      OP_NOR:   alu_res = ~(src1_i | src2_i);
      OP_SHIFT: alu_res = DATA_W'($signed(src2_i) >>> amt);
      default:  alu_res = '0;
    endcase
  end

  alu_mul_iter u_mul (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (mul_start),
    .a       (src1_i),
    .b       (src2_i),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (mul_start) next_state = MUL;
      MUL:     if (mul_done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // MUL completion and a new accept are exclusive: accept needs busy_o low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_o <= '0;
      zero_o   <= 1'b0;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      busy_o  <= (next_state == MUL);
      if (mul_done) begin
        result_o <= mul_prod;
        zero_o   <= (mul_prod == '0);
        valid_o  <= 1'b1;
      end else if (accept && !mul_start) begin
        result_o <= alu_res;
        zero_o   <= (alu_res == '0);
        valid_o  <= 1'b1;
      end
    end
  end

endmodule
